nn_train_seq: RTL and testbench

- Training-loop sequencer for the backprop weight datapath: drives the `select_initial` / `select_update` strobes shared by all weight registers, plus forward/backward enables for the neuron and delta datapaths.
- Walks N_SAMPLES training samples per epoch for N_EPOCHS epochs, then pulses `done`.
- Sits between the top-level host/testbench controller and the weight, neuron and delta blocks.

---
 rtl/nn_train_seq.sv | 125 ++++++++++++
 tb/tb_nn_train_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/nn_train_seq.sv
// Training-loop sequencer: walks N_SAMPLES samples per epoch for N_EPOCHS epochs,
// strobing weight init/update and forward/backward enables as a Moore FSM.
module nn_train_seq #(
  parameter int N_SAMPLES  = 4,
  parameter int N_EPOCHS   = 1000,
  parameter int FWD_CYCLES = 3,
  parameter int BWD_CYCLES = 4,
  parameter int IDX_W      = 2,
  parameter int EP_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  output logic             select_initial,
  output logic             select_update,
  output logic             fwd_en,
  output logic             bwd_en,
  output logic [IDX_W-1:0] sample_idx,
  output logic [EP_W-1:0]  epoch,
  output logic             busy,
  output logic             done
);

  localparam int CYC_MAX = (FWD_CYCLES > BWD_CYCLES) ? FWD_CYCLES : BWD_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FWD, S_BWD, S_UPD, S_DONE
  } state_t;

  state_t           state;
  logic [CYC_W-1:0] cyc;
  // {select_initial, select_update, fwd_en, bwd_en, done, busy}
  logic [5:0]       outs;

  // Output pattern of the state being entered, so the strobes are registered
  // alongside the state itself.
  function automatic logic [5:0] dec(input state_t s);
    case (s)
      S_INIT:  dec = 6'b100001;
      S_FWD:   dec = 6'b001001;
      S_BWD:   dec = 6'b000101;
      S_UPD:   dec = 6'b010001;
      S_DONE:  dec = 6'b000011;
      default: dec = 6'b000000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset || (stop && state != S_IDLE)) begin
      state      <= S_IDLE;
      outs       <= '0;
      cyc        <= '0;
      sample_idx <= '0;
      epoch      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            state      <= S_INIT;
            outs       <= dec(S_INIT);
            cyc        <= '0;
            sample_idx <= '0;
            epoch      <= '0;
          end
        end
        S_INIT: begin
          state <= S_FWD;
          outs  <= dec(S_FWD);
          cyc   <= '0;
        end
        S_FWD: begin
          if (cyc == CYC_W'(FWD_CYCLES - 1)) begin
            state <= S_BWD;
            outs  <= dec(S_BWD);
            cyc   <= '0;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_BWD: begin
          if (cyc == CYC_W'(BWD_CYCLES - 1)) begin
            state <= S_UPD;
            outs  <= dec(S_UPD);
            cyc   <= '0;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_UPD: begin
          if (sample_idx != IDX_W'(N_SAMPLES - 1)) begin
            sample_idx <= sample_idx + 1'b1;
            state      <= S_FWD;
            outs       <= dec(S_FWD);
          end else if (epoch != EP_W'(N_EPOCHS - 1)) begin
            sample_idx <= '0;
            epoch      <= epoch + 1'b1;
            state      <= S_FWD;
            outs       <= dec(S_FWD);
          end else begin
            state <= S_DONE;
            outs  <= dec(S_DONE);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          outs  <= dec(S_IDLE);
        end
        default: begin
          state <= S_IDLE;
          outs  <= '0;
        end
      endcase
    end
  end

  assign select_initial = outs[5];
  assign select_update  = outs[4];
  assign fwd_en         = outs[3];
  assign bwd_en         = outs[2];
  assign done           = outs[1];
  assign busy           = outs[0];

endmodule

// File: tb/tb_nn_train_seq.sv
// Directed bench for nn_train_seq: full 2-epoch run, stop/reset aborts and a
// minimal 1x1 configuration, checked cycle by cycle against hand-derived values.
module tb_nn_train_seq;

  logic clk = 1'b0;
  logic reset, start, stop, start2, stop2;

  logic        si1, su1, fwd1, bwd1, busy1, done1;
  logic [1:0]  sidx1;
  logic [15:0] ep1;
  logic        si2, su2, fwd2, bwd2, busy2, done2;
  logic [1:0]  sidx2;
  logic [15:0] ep2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nn_train_seq #(
    .N_SAMPLES(4), .N_EPOCHS(2), .FWD_CYCLES(3), .BWD_CYCLES(4), .IDX_W(2), .EP_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .select_initial(si1), .select_update(su1), .fwd_en(fwd1), .bwd_en(bwd1),
    .sample_idx(sidx1), .epoch(ep1), .busy(busy1), .done(done1)
  );

  nn_train_seq #(
    .N_SAMPLES(1), .N_EPOCHS(1), .FWD_CYCLES(1), .BWD_CYCLES(1), .IDX_W(2), .EP_W(16)
  ) dut_small (
    .clk(clk), .reset(reset), .start(start2), .stop(stop2),
    .select_initial(si2), .select_update(su2), .fwd_en(fwd2), .bwd_en(bwd2),
    .sample_idx(sidx2), .epoch(ep2), .busy(busy2), .done(done2)
  );

  // Packed view: {si, su, fwd, bwd, done, busy, sample_idx[1:0], epoch[15:0]}
  function automatic logic [23:0] mk(input logic si, su, f, b, d, bz,
                                     input logic [1:0] s, input logic [15:0] e);
    mk = {si, su, f, b, d, bz, s, e};
  endfunction

  wire [23:0] obs1 = {si1, su1, fwd1, bwd1, done1, busy1, sidx1, ep1};
  wire [23:0] obs2 = {si2, su2, fwd2, bwd2, done2, busy2, sidx2, ep2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] exp;
    int n_si, n_su, n_done, n_both;
    int p;
    reset = 1'b0; start = 1'b0; stop = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    tick();
    tick();
    chk("reset_state", 32'(obs1), 32'(24'h0));
    chk("reset_state_small", 32'(obs2), 32'(24'h0));
    reset = 1'b1;

    // Run 1: start held high for the whole run; must not restart while busy.
    n_si = 0; n_su = 0; n_done = 0; n_both = 0;
    start = 1'b1;
    for (int c = 1; c <= 68; c++) begin
      tick();
      if (c == 1)
        exp = mk(1, 0, 0, 0, 0, 1, 2'd0, 16'd0);
      else if (c <= 65) begin
        p   = (c - 2) % 8;
        exp = mk(0, p == 7, p < 3, (p >= 3) && (p < 7), 0, 1,
                 2'(((c - 2) / 8) % 4), 16'((c - 2) / 32));
      end else if (c == 66)
        exp = mk(0, 0, 0, 0, 1, 1, 2'd3, 16'd1);
      else if (c == 67)
        exp = mk(0, 0, 0, 0, 0, 0, 2'd3, 16'd1);
      else
        exp = mk(1, 0, 0, 0, 0, 1, 2'd0, 16'd0);
      chk($sformatf("run1_c%0d", c), 32'(obs1), 32'(exp));
      if (c <= 67) begin
        n_si   += int'(si1);
        n_su   += int'(su1);
        n_done += int'(done1);
        n_both += int'(si1 & su1);
      end
    end
    chk("count_select_update", n_su, 8);
    chk("count_select_initial", n_si, 1);
    chk("count_done", n_done, 1);
    chk("init_update_coincident", n_both, 0);

    // Abort the restarted run straight from INIT.
    start = 1'b0; stop = 1'b1;
    tick();
    chk("stop_in_init", 32'(obs1), 32'(24'h0));
    stop = 1'b0;

    // Run 2: stop mid-FWD in cycle 20.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 20; c++) tick();
    chk("c20_fwd", 32'(obs1), 32'(mk(0, 0, 1, 0, 0, 1, 2'd2, 16'd0)));
    stop = 1'b1;
    tick();
    chk("stop_mid_fwd", 32'(obs1), 32'(24'h0));
    stop = 1'b0;
    n_su = 0; n_done = 0; p = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_su   += int'(su1);
      n_done += int'(done1);
      p      += int'(busy1);
    end
    chk("after_stop_no_update", n_su, 0);
    chk("after_stop_no_done", n_done, 0);
    chk("after_stop_idle", p, 0);

    // Run 3: stop sampled during UPD still shows the update strobe that cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 9; c++) tick();
    chk("c9_upd", 32'(obs1), 32'(mk(0, 1, 0, 0, 0, 1, 2'd0, 16'd0)));
    stop = 1'b1;
    tick();
    chk("stop_in_upd", 32'(obs1), 32'(24'h0));

    // start and stop together in IDLE: stop wins.
    start = 1'b1;
    tick();
    chk("start_stop_idle", 32'(obs1), 32'(24'h0));
    start = 1'b0; stop = 1'b0;

    // Run 4: reset low in cycle 30 for one cycle, restart in cycle 35.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 30; c++) tick();
    chk("c30_running", 32'(busy1), 32'(1));
    reset = 1'b0;
    tick();
    chk("reset_midrun", 32'(obs1), 32'(24'h0));
    reset = 1'b1;
    for (int c = 32; c <= 35; c++) tick();
    chk("c35_idle", 32'(obs1), 32'(24'h0));
    start = 1'b1;
    tick();
    chk("c36_init", 32'(obs1), 32'(mk(1, 0, 0, 0, 0, 1, 2'd0, 16'd0)));
    start = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;

    // Run 5: 1 sample, 1 epoch, 1+1 cycle passes.
    start2 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start2 = 1'b0;
      case (c)
        1: exp = mk(1, 0, 0, 0, 0, 1, 2'd0, 16'd0);
        2: exp = mk(0, 0, 1, 0, 0, 1, 2'd0, 16'd0);
        3: exp = mk(0, 0, 0, 1, 0, 1, 2'd0, 16'd0);
        4: exp = mk(0, 1, 0, 0, 0, 1, 2'd0, 16'd0);
        5: exp = mk(0, 0, 0, 0, 1, 1, 2'd0, 16'd0);
        default: exp = mk(0, 0, 0, 0, 0, 0, 2'd0, 16'd0);
      endcase
      chk($sformatf("small_c%0d", c), 32'(obs2), 32'(exp));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
